pytxarqbufctrl_mlt: RTL

- Per-logical-transport (LT_ADDR) transmit ACL buffer controller with ping-pong halves per LT, driven by ARQN/FLOW/SEQN (Vol2 PartB 7.6).
- Generalises the single global s1a toggle into NUM_LT independent channels with automatic retransmit, flow-stop hold, SEQN generation and MCU commit handshake.
- Sits between the MCU buffer port (bsm side) and the payload encoder (lnctrl side); drives the buffer RAM addresses only, not the data.

---
 rtl/pytxarqbufctrl_mlt.sv | 173 +++++++++++++++++
 1 files changed

// File: rtl/pytxarqbufctrl_mlt.sv
// Per-LT transmit ACL buffer controller: ping-pong half select, ARQN/FLOW driven
// retransmit decision, SEQN generation and MCU commit handshake for NUM_LT channels.
module pytxarqbufctrl_mlt #(
  parameter int NUM_LT  = 8,
  parameter int LT_W    = 3,
  parameter int WADDR_W = 6
) (
  input  logic                      clk_6M,
  input  logic                      rst,
  input  logic                      mcu_commit_p,
  input  logic [LT_W-1:0]           mcu_lt,
  input  logic [WADDR_W-1:0]        mcu_waddr,
  input  logic                      flush_p,
  input  logic [LT_W-1:0]           flush_lt,
  input  logic                      tx_packet_st_p,
  input  logic [LT_W-1:0]           tx_lt,
  input  logic [WADDR_W-1:0]        lnctrl_waddr,
  input  logic                      rx_hdr_p,
  input  logic [LT_W-1:0]           rx_lt,
  input  logic                      rx_hecgood,
  input  logic                      rx_arqn,
  input  logic                      rx_flow,
  output logic [LT_W+WADDR_W:0]     mcu_addr,
  output logic [LT_W+WADDR_W:0]     lnctrl_addr,
  output logic                      txdec_p,
  output logic                      txpy_new,
  output logic                      txpy_retx,
  output logic                      txnull,
  output logic                      seqn_out,
  output logic                      newpy_int_p,
  output logic [NUM_LT-1:0]         regi_txbufempty,
  output logic                      regi_commit_ovf
);

  logic [NUM_LT-1:0] s1a_q, s1a_d, pending_q, pending_d, acked_q, acked_d;
  logic [NUM_LT-1:0] flow_go_q, flow_go_d, seqn_q, seqn_d, pend_eff;
  logic [LT_W-1:0]   tx_lt_q, tx_lt_d;
  logic              ovf_q, ovf_d, txdec_q, txdec_d, new_q, new_d, retx_q, retx_d;
  logic              null_q, null_d, seqn_out_q, seqn_out_d, newpy_q, newpy_d;
  logic              acked_eff;

  // Next-state: commit first, then tx decision on pre-rx state, then rx, then flush wins.
  always_comb begin
    s1a_d      = s1a_q;
    acked_d    = acked_q;
    flow_go_d  = flow_go_q;
    seqn_d     = seqn_q;
    tx_lt_d    = tx_lt_q;
    ovf_d      = ovf_q;
    txdec_d    = 1'b0;
    newpy_d    = 1'b0;
    new_d      = new_q;
    retx_d     = retx_q;
    null_d     = null_q;
    seqn_out_d = seqn_out_q;
    pend_eff   = pending_q;

    if (mcu_commit_p) begin
      if (pending_q[mcu_lt]) ovf_d = 1'b1;
      else                   pend_eff[mcu_lt] = 1'b1;
    end else begin
      ovf_d = ovf_q;
    end
    pending_d = pend_eff;
    acked_eff = acked_q[tx_lt] | (tx_lt == {LT_W{1'b0}});

    if (tx_packet_st_p) begin
      tx_lt_d    = tx_lt;
      txdec_d    = 1'b1;
      new_d      = 1'b0;
      retx_d     = 1'b0;
      null_d     = 1'b0;
      seqn_out_d = 1'b0;
      if (!flow_go_q[tx_lt]) begin
        null_d = 1'b1;
      end else if (!acked_eff) begin
        retx_d     = 1'b1;
        seqn_out_d = seqn_q[tx_lt];
      end else if (pend_eff[tx_lt]) begin
        new_d              = 1'b1;
        newpy_d            = 1'b1;
        s1a_d[tx_lt]       = ~s1a_q[tx_lt];
        pending_d[tx_lt]   = 1'b0;
        if (tx_lt != {LT_W{1'b0}}) begin
          seqn_d[tx_lt]  = ~seqn_q[tx_lt];
          seqn_out_d     = ~seqn_q[tx_lt];
          acked_d[tx_lt] = 1'b0;
        end else begin
          seqn_out_d = 1'b0;
        end
      end else begin
        null_d = 1'b1;
      end
    end else begin
      tx_lt_d = tx_lt_q;
    end

    // LT 0 is broadcast: no ARQ, so its flow/ack state ignores received headers
    if (rx_hdr_p && rx_hecgood && (rx_lt != {LT_W{1'b0}})) begin
      flow_go_d[rx_lt] = rx_flow;
      if (rx_arqn) acked_d[rx_lt] = 1'b1;
      else         acked_d[rx_lt] = acked_d[rx_lt];
    end else begin
      flow_go_d = flow_go_d;
    end

    if (flush_p) begin
      s1a_d[flush_lt]     = 1'b0;
      pending_d[flush_lt] = 1'b0;
      acked_d[flush_lt]   = 1'b1;
      flow_go_d[flush_lt] = 1'b1;
      seqn_d[flush_lt]    = 1'b0;
      if (tx_lt_d == flush_lt) begin
        txdec_d    = 1'b0;
        newpy_d    = 1'b0;
        new_d      = 1'b0;
        retx_d     = 1'b0;
        null_d     = 1'b0;
        seqn_out_d = 1'b0;
      end else begin
        txdec_d = txdec_d;
      end
    end else begin
      seqn_d = seqn_d;
    end
    acked_d[0] = 1'b1;
  end

  // State and registered decision outputs.
  always_ff @(posedge clk_6M) begin
    if (rst) begin
      s1a_q      <= {NUM_LT{1'b0}};
      pending_q  <= {NUM_LT{1'b0}};
      acked_q    <= {NUM_LT{1'b1}};
      flow_go_q  <= {NUM_LT{1'b1}};
      seqn_q     <= {NUM_LT{1'b0}};
      tx_lt_q    <= {LT_W{1'b0}};
      ovf_q      <= 1'b0;
      txdec_q    <= 1'b0;
      new_q      <= 1'b0;
      retx_q     <= 1'b0;
      null_q     <= 1'b0;
      seqn_out_q <= 1'b0;
      newpy_q    <= 1'b0;
    end else begin
      s1a_q      <= s1a_d;
      pending_q  <= pending_d;
      acked_q    <= acked_d;
      flow_go_q  <= flow_go_d;
      seqn_q     <= seqn_d;
      tx_lt_q    <= tx_lt_d;
      ovf_q      <= ovf_d;
      txdec_q    <= txdec_d;
      new_q      <= new_d;
      retx_q     <= retx_d;
      null_q     <= null_d;
      seqn_out_q <= seqn_out_d;
      newpy_q    <= newpy_d;
    end
  end

  assign mcu_addr        = {mcu_lt, ~s1a_q[mcu_lt], mcu_waddr};
  assign lnctrl_addr     = {tx_lt_q, s1a_q[tx_lt_q], lnctrl_waddr};
  assign txdec_p         = txdec_q;
  assign txpy_new        = new_q;
  assign txpy_retx       = retx_q;
  assign txnull          = null_q;
  assign seqn_out        = seqn_out_q;
  assign newpy_int_p     = newpy_q;
  assign regi_txbufempty = ~pending_q;
  assign regi_commit_ovf = ovf_q;

endmodule
